// File: rtl/inst_store.sv
// Program store and instruction source: streaming load, then pipelined fetch.
// Optional build macro INST_CHECK_EN screens opcodes at write time.
module inst_store #(
  parameter int              DEPTH        = 16,
  parameter int              AW           = 4,
  parameter int              DW           = 32,
  parameter int              READ_LATENCY = 1,
  parameter logic [DW-1:0]   STOP_WORD    = 32'hFF00_0000
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          LoadStart,
  input  logic          LoadValid,
  input  logic [DW-1:0] LoadData,
  input  logic          LoadDone,
  output logic          LoadReady,
  output logic [AW:0]   LoadCount,
  input  logic          Enable,
  input  logic [AW-1:0] Address,
  output logic [DW-1:0] DataOut,
  output logic          ProgReady,
  output logic          Overflow,
  output logic          IllegalInst
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam int          LAST     = READ_LATENCY - 1;

  state_t                 state_q, state_d;
  logic [AW:0]            count_q, count_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic                   overflow_q, overflow_d;
  logic                   illegal_q, illegal_d;
  logic [DW-1:0]          data_q, data_d;
  logic [DW-1:0]          mem_q [DEPTH];
  logic [READ_LATENCY-1:0] rd_vld_q;
  logic [AW-1:0]          rd_addr_q [READ_LATENCY];

  logic          load_ready;
  logic          wr_en;
  logic          wr_illegal;
  logic [DW-1:0] wr_word;
  logic [AW-1:0] wr_ptr;
  logic          rd_take;

  // The write pointer is the low bits of the word count; they advance together.
  assign wr_ptr     = count_q[AW-1:0];
  assign load_ready = (state_q == S_LOAD) && (count_q < FULL_CNT);

`ifdef INST_CHECK_EN
  logic [7:0] opcode;
  assign opcode     = LoadData[DW-1:DW-8];
  assign wr_illegal = !((opcode >= 8'h01 && opcode <= 8'h05) || opcode == 8'hFF);
  assign wr_word    = wr_illegal ? STOP_WORD : LoadData;
`else
  assign wr_illegal = 1'b0;
  assign wr_word    = LoadData;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    wr_en      = 1'b0;
    if (LoadStart) begin
      state_d    = S_LOAD;
      count_d    = '0;
      valid_d    = '0;
      overflow_d = 1'b0;
      illegal_d  = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (LoadValid) begin
            if (load_ready) begin
              wr_en           = 1'b1;
              valid_d[wr_ptr] = 1'b1;
              count_d         = count_q + (AW+1)'(1);
              if (wr_illegal) illegal_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (LoadDone) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // A reload discards reads in flight and leaves DataOut untouched.
  assign rd_take = (state_q == S_RUN) && Enable && !LoadStart;

  always_comb begin
    data_d = data_q;
    if (!LoadStart && (state_q == S_RUN) && rd_vld_q[LAST]) begin
      data_d = valid_q[rd_addr_q[LAST]] ? mem_q[rd_addr_q[LAST]] : STOP_WORD;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      data_q     <= '0;
      rd_vld_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      data_q     <= data_d;
      if (LoadStart) begin
        rd_vld_q <= '0;
      end else begin
        rd_vld_q[0] <= rd_take;
        for (int i = 1; i < READ_LATENCY; i++) rd_vld_q[i] <= rd_vld_q[i-1];
      end
    end
  end

  // NOTE: storage and read addresses are not reset; the valid bits and the
  // read-valid pipeline decide whether their contents are ever observed.
  always_ff @(posedge Clock) begin
    if (wr_en) mem_q[wr_ptr] <= wr_word;
    rd_addr_q[0] <= Address;
    for (int i = 1; i < READ_LATENCY; i++) rd_addr_q[i] <= rd_addr_q[i-1];
  end

  assign LoadReady   = load_ready;
  assign LoadCount   = count_q;
  assign DataOut     = data_q;
  assign ProgReady   = (state_q == S_RUN);
  assign Overflow    = overflow_q;
  assign IllegalInst = illegal_q;

endmodule

// File: tb/tb_inst_store.sv
// Directed bench for inst_store: load, fetch latency, overflow, reset abort, reload, opcode screening.
module tb_inst_store;

  localparam logic [31:0] STOP = 32'hFF00_0000;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        LoadStart, LoadValid, LoadDone, Enable;
  logic [31:0] LoadData;
  logic [3:0]  Address;
  logic        LoadReady, ProgReady, Overflow, IllegalInst;
  logic [4:0]  LoadCount;
  logic [31:0] DataOut;

  int n_checks = 0;
  int n_fail   = 0;

  inst_store #(.DEPTH(16), .AW(4), .DW(32), .READ_LATENCY(1), .STOP_WORD(32'hFF00_0000)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData), .LoadDone(LoadDone),
    .LoadReady(LoadReady), .LoadCount(LoadCount),
    .Enable(Enable), .Address(Address), .DataOut(DataOut),
    .ProgReady(ProgReady), .Overflow(Overflow), .IllegalInst(IllegalInst)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    LoadValid = 1'b1; LoadData = w;
    tick();
    LoadValid = 1'b0;
  endtask

  task automatic start_load();
    LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
  endtask

  task automatic finish_load();
    LoadDone = 1'b1;
    tick();
    LoadDone = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] a, input logic [31:0] exp, input string tag);
    Enable = 1'b1; Address = a;
    tick();
    Enable = 1'b0;
    tick();
    check(tag, DataOut, exp);
  endtask

  initial begin
    Reset_n = 1'b0; LoadStart = 1'b0; LoadValid = 1'b0; LoadDone = 1'b0;
    LoadData = '0; Enable = 1'b0; Address = '0;
    tick(); tick();
    check("rst_ready", LoadReady, 0);
    check("rst_count", LoadCount, 0);
    check("rst_data", DataOut, 0);
    check("rst_prog", ProgReady, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_ill", IllegalInst, 0);
    Reset_n = 1'b1;
    tick();

    // Enable is ignored in IDLE.
    Enable = 1'b1; Address = 4'd3;
    tick(); tick();
    Enable = 1'b0;
    check("idle_hold", DataOut, 0);

    // Three-word program.
    start_load();
    check("load_ready", LoadReady, 1);
    check("load_cnt0", LoadCount, 0);
    load_word(32'h0112_2213);
    load_word(32'h0313_2131);
    load_word(32'hFF00_0000);
    check("load_cnt3", LoadCount, 3);
    check("prog_before_done", ProgReady, 0);
    finish_load();
    check("prog_ready", ProgReady, 1);
    check("run_ready_low", LoadReady, 0);
    check("run_cnt3", LoadCount, 3);

    Enable = 1'b1; Address = 4'd1;
    tick();
    Enable = 1'b0;
    check("lat_not_yet", DataOut, 0);
    tick();
    check("fetch_a1", DataOut, 32'h0313_2131);
    tick();
    check("hold_idle_en", DataOut, 32'h0313_2131);
    fetch(4'd7, STOP, "fetch_unloaded");
    fetch(4'd0, 32'h0112_2213, "fetch_a0");
    fetch(4'd2, STOP, "fetch_stop_word");

    // Seventeen words back to back; the last is dropped.
    start_load();
    for (int i = 1; i <= 17; i++) begin
      if (i == 16) check("ready_w16", LoadReady, 1);
      if (i == 17) begin
        check("ready_w17", LoadReady, 0);
        check("ovf_before", Overflow, 0);
      end
      LoadValid = 1'b1; LoadData = 32'h0100_0000 + 32'(i);
      tick();
    end
    LoadValid = 1'b0;
    check("ovf_set", Overflow, 1);
    check("full_cnt", LoadCount, 16);
    finish_load();
    check("ovf_sticky", Overflow, 1);
    fetch(4'd15, 32'h0100_0010, "fetch_a15");

    // Enable held for three cycles at the same address.
    Enable = 1'b1; Address = 4'd0;
    tick();
    check("hold_c0", DataOut, 32'h0100_0010);
    tick();
    check("hold_c1", DataOut, 32'h0100_0001);
    tick();
    check("hold_c2", DataOut, 32'h0100_0001);
    Enable = 1'b0;
    tick();
    check("hold_c3", DataOut, 32'h0100_0001);
    tick();
    check("hold_en_low", DataOut, 32'h0100_0001);

    // Pipelined back-to-back reads of different slots.
    Enable = 1'b1; Address = 4'd4;
    tick();
    Address = 4'd9;
    tick();
    check("pipe_a4", DataOut, 32'h0100_0005);
    Enable = 1'b0;
    tick();
    check("pipe_a9", DataOut, 32'h0100_000A);

    // Reset in the middle of a load aborts it.
    start_load();
    load_word(32'h0200_00AA);
    load_word(32'h0200_00BB);
    Reset_n = 1'b0;
    #2;
    check("midrst_cnt", LoadCount, 0);
    check("midrst_data", DataOut, 0);
    check("midrst_ovf", Overflow, 0);
    tick();
    Reset_n = 1'b1;
    tick();
    start_load();
    load_word(32'h0400_0044);
    finish_load();
    check("reload_cnt", LoadCount, 1);
    fetch(4'd0, 32'h0400_0044, "reload_a0");
    fetch(4'd1, STOP, "reload_a1_stop");

    // LoadStart in RUN discards the in-flight read.
    Enable = 1'b1; Address = 4'd0;
    tick();
    Enable = 1'b0; LoadStart = 1'b1;
    tick();
    LoadStart = 1'b0;
    check("restart_prog", ProgReady, 0);
    check("restart_discard", DataOut, STOP);
    check("restart_cnt", LoadCount, 0);
    tick();
    check("restart_hold", DataOut, STOP);

    // Word and LoadDone together: word is stored, then RUN.
    LoadValid = 1'b1; LoadDone = 1'b1; LoadData = 32'h0700_0000;
    tick();
    LoadValid = 1'b0; LoadDone = 1'b0;
    check("done_wr_cnt", LoadCount, 1);
    check("done_wr_prog", ProgReady, 1);
`ifdef INST_CHECK_EN
    fetch(4'd0, STOP, "illegal_word");
    check("illegal_flag", IllegalInst, 1);
`else
    fetch(4'd0, 32'h0700_0000, "verbatim_word");
    check("illegal_flag", IllegalInst, 0);
`endif

    // LoadStart wins over LoadDone; then an empty program.
    LoadStart = 1'b1; LoadDone = 1'b1;
    tick();
    LoadStart = 1'b0; LoadDone = 1'b0;
    check("prio_prog", ProgReady, 0);
    check("prio_ill_clr", IllegalInst, 0);
    finish_load();
    check("empty_cnt", LoadCount, 0);
    check("empty_prog", ProgReady, 1);
    fetch(4'd0, STOP, "empty_a0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_store.md
Name: inst_store

Overview:
- Program store and instruction source for the execution engine.
- Accepts a program through a streaming load handshake, then serves 32-bit instructions on the engine's fetch request.
- Fetch request is the engine's instruction-register enable plus the 4-bit PC address.
- Unloaded or out-of-range slots return the stop instruction, so a short program always halts cleanly.

Parameters:
- DEPTH, 16: number of instruction slots; must equal 2**AW.
- AW, 4: address width; matches the engine's Address bus.
- DW, 32: instruction width.
- READ_LATENCY, 1: cycles from sampled fetch request to DataOut valid; legal values 1 or 2. Both fit inside the engine's 3-cycle fetch stall.
- STOP_WORD, 32'hFF00_0000: word returned for unloaded slots (opcode 8'hFF).

Ports:
- Clock  in  1: rising-edge clock.
- Reset_n  in  1: asynchronous, active-low reset.
- LoadStart  in  1: begin a (re)load; clears all slots.
- LoadValid  in  1: LoadData is valid this cycle.
- LoadData  in  DW: instruction word to store.
- LoadDone  in  1: end of load; enter RUN.
- LoadReady  out  1: store accepts a word this cycle.
- LoadCount  out  AW+1: words stored since LoadStart, 0..DEPTH.
- Enable  in  1: fetch request (engine Enable[3]).
- Address  in  AW: slot to read (engine PC).
- DataOut  out  DW: instruction to engine DataIn.
- ProgReady  out  1: program loaded, fetches are served.
- Overflow  out  1: sticky; a word was offered while full.
- IllegalInst  out  1: sticky; see Optional Feature.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State IDLE; all valid bits cleared; write pointer = 0.
  - LoadReady=0, LoadCount=0, DataOut=0, ProgReady=0, Overflow=0, IllegalInst=0.
  - Read pipeline flushed.
  - Reset mid-load or mid-read aborts the operation; no partial write survives.
- States: IDLE, LOAD, RUN.
- IDLE:
  - LoadStart=1 -> LOAD; clear valid bits, pointer, LoadCount, Overflow and IllegalInst.
  - Enable is ignored and DataOut holds.
- LOAD:
  - LoadReady = (LoadCount < DEPTH).
  - LoadValid & LoadReady: write mem[ptr]; set valid[ptr]; ptr++ and LoadCount++ at the same edge.
  - LoadValid & !LoadReady: word dropped, Overflow set.
  - LoadDone -> RUN at the same edge. If LoadValid is also high that edge, the word is written first, then RUN.
  - LoadDone with LoadCount=0 -> RUN; every fetch then returns STOP_WORD.
  - LoadStart during LOAD restarts the load from slot 0.
- RUN:
  - ProgReady=1 and LoadReady=0.
  - Enable sampled high at edge N captures Address.
  - DataOut updates at edge N+READ_LATENCY to mem[Address] if valid, else STOP_WORD.
  - Enable held high for multiple cycles: fully pipelined, one read per cycle. The engine's repeated same-address requests return the same word.
  - Enable low: DataOut holds its last value.
  - LoadStart in RUN -> LOAD: ProgReady=0 next edge; in-flight reads are discarded and DataOut holds.
- LoadStart has priority over LoadDone when both are high.
- The Address bus is never checked for X; the engine guarantees it is stable while Enable=1.

Optional Feature:
- Macro INST_CHECK_EN.
- When defined, each word is checked at write time:
  - Legal opcodes ([31:24]) are 8'h01 to 8'h05 and 8'hFF.
  - An illegal opcode is stored as STOP_WORD and IllegalInst is set (sticky until next LoadStart).
  - LoadCount still increments.
- When undefined: words are stored verbatim and IllegalInst is tied 0.

Test Plan:
- Reset, LoadStart, load 3 words {32'h01_12_22_13, 32'h03_13_21_31, 32'hFF000000}, LoadDone -> LoadCount=3, ProgReady=1; Enable with Address=1 gives DataOut=32'h03132131 exactly 1 cycle later (READ_LATENCY=1).
- After the 3-word load, fetch Address=7 -> DataOut=32'hFF000000.
- Load 17 words back-to-back -> LoadReady drops after word 16, word 17 dropped, Overflow=1, LoadCount=16; Address=15 returns word 16.
- In RUN hold Enable=1 for 3 cycles at Address=0 -> DataOut stable at word 0 from cycle 1; engine-style 3-cycle stall samples the correct word.
- Assert Reset_n=0 mid-load after 2 words, then reload 1 word -> Address=1 returns STOP_WORD; LoadStart during RUN clears ProgReady next cycle.
- With INST_CHECK_EN, load 32'h07_00_00_00 -> Address=0 returns 32'hFF000000 and IllegalInst=1. Without the macro, the same load returns 32'h07000000 and IllegalInst=0.
